// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-to-8 active-low decoder through channels 0..7.
// Each channel is enabled for DWELL cycles, separated by BLANK cycles with
// enable low. A scan runs once (mode=1) or repeats until stopped (mode=0).
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset
//   start  - begin a scan (sampled only in IDLE)
//   stop   - abort the scan (sampled in any state)
//   mode   - 0 = continuous, 1 = single pass (latched with start)
//   sel    - registered channel select to the decoder
//   enable - registered decoder enable
//   busy   - registered, high while dwelling or blanking
//   done   - registered one-cycle pulse when a single pass completes
module scan_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic [2:0] sel,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEL_W = 3;

  // Counter reload values; the counter counts down to zero, so a phase of
  // N cycles loads N-1 on entry.
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_RELOAD = (BLANK != 0) ? CNT_W'(BLANK - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_CH      = SEL_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [SEL_W-1:0]  sel_d;
  logic              enable_d;
  logic              busy_d;
  logic              done_d;

  // State, counter, latched mode and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sel     <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sel     <= sel_d;
      enable  <= enable_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so they appear together with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sel_d    = sel;
    enable_d = enable;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d    = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        if (start && !stop) begin
          state_d  = ST_DWELL;
          cnt_d    = DWELL_RELOAD;
          mode_d   = mode;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      ST_DWELL: begin
        if (stop) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sel_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((sel == LAST_CH) && mode_q) begin
          // End of a single pass: no blank after the last channel.
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sel_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (BLANK != 0) begin
          state_d  = ST_BLANK;
          cnt_d    = BLANK_RELOAD;
          enable_d = 1'b0;
        end else begin
          // Zero blank: move straight to the next channel, enable stays high.
          cnt_d = DWELL_RELOAD;
          sel_d = sel + SEL_W'(1);
        end
      end

      ST_BLANK: begin
        if (stop) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          sel_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // sel wraps 7 -> 0 in continuous mode by natural overflow.
          state_d  = ST_DWELL;
          cnt_d    = DWELL_RELOAD;
          sel_d    = sel + SEL_W'(1);
          enable_d = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        sel_d    = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule
